registradores_param: RTL

REGISTRADORES_PARAM -- requirements
Module: registradores_param

---
 rtl/registradores_param_pkg.sv | 13 +
 rtl/regfile_rdport.sv | 47 ++++
 rtl/registradores_param.sv | 103 ++++++++++
 3 files changed

// File: rtl/registradores_param_pkg.sv
// Shared FSM encodings and default datapath constants for the parameterised register file.
package registradores_param_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NRP   = 2;

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: 1-cycle latency, write-first bypass, register 0 reads as zero.
module regfile_rdport #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_run,
    input  logic            i_rd_en,
    input  logic [AW-1:0]   i_raddr,
    input  logic [XLEN-1:0] i_mem_word,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_rvalid
);

    logic [XLEN-1:0] r_rdata;
    logic            r_rvalid;
    logic [XLEN-1:0] w_rd_word;

    // A same-edge write to the addressed register wins over the stored value.
    always_comb begin
        w_rd_word = i_mem_word;
        if (i_raddr == '0)
            w_rd_word = '0;
        else if (i_we && (i_waddr == i_raddr))
            w_rd_word = i_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else if (i_run && i_rd_en) begin
            r_rdata  <= w_rd_word;
            r_rvalid <= 1'b1;
        end else begin
            r_rvalid <= 1'b0;
        end
    end

    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;

endmodule

// File: rtl/registradores_param.sv
// Register file with NRP read ports and one write port; zeroed by a sweep after reset (busy for NREGS cycles).
module registradores_param
    import registradores_param_pkg::*;
#(
    parameter  int XLEN  = DEF_XLEN,
    parameter  int NREGS = DEF_NREGS,
    parameter  int NRP   = DEF_NRP,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRP-1:0]      rd_en,
    input  logic [NRP*AW-1:0]   raddr,
    output logic [NRP*XLEN-1:0] rdata,
    output logic [NRP-1:0]      rvalid,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    output logic                busy
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_clr_cnt;
    logic [XLEN-1:0] r_regs [NREGS];

    logic            w_run;
    logic            w_wr_en;
    logic [AW-1:0]   w_wr_addr;
    logic [XLEN-1:0] w_wr_data;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_CLEAR;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == ST_CLEAR) && (r_clr_cnt == AW'(NREGS - 1)))
            w_state_nxt = ST_RUN;
    end

    always_comb begin
        busy  = (r_state == ST_CLEAR);
        w_run = (r_state == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_CLEAR))
            r_clr_cnt <= '0;
        else
            r_clr_cnt <= r_clr_cnt + 1'b1;
    end

    // Single write port shared by the clear sweep and user writes; writes to register 0 are dropped.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = waddr;
        w_wr_data = wdata;
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_clr_cnt;
                w_wr_data = '0;
            end else if (we && (waddr != '0)) begin
                w_wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_regs[w_wr_addr] <= w_wr_data;
    end

    for (genvar gi = 0; gi < NRP; gi++) begin : g_rdport
        logic [AW-1:0]   w_raddr;
        logic [XLEN-1:0] w_mem_word;

        assign w_raddr    = raddr[gi*AW +: AW];
        assign w_mem_word = r_regs[w_raddr];

        regfile_rdport #(
            .XLEN (XLEN),
            .AW   (AW)
        ) u_rdport (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_run      (w_run),
            .i_rd_en    (rd_en[gi]),
            .i_raddr    (w_raddr),
            .i_mem_word (w_mem_word),
            .i_we       (we),
            .i_waddr    (waddr),
            .i_wdata    (wdata),
            .o_rdata    (rdata[gi*XLEN +: XLEN]),
            .o_rvalid   (rvalid[gi])
        );
    end

endmodule
